// File: rtl/adder64_arbiter_if.sv
// rtl/adder64_arbiter_if.sv - two-requester shared-adder bus with result channel
// Sub0/Sub1 exist only when ADDER64_ARB_SUB_EN is defined.
interface adder64_arbiter_if;
    logic        Req0;
    logic [63:0] X0;
    logic [63:0] Y0;
    logic        CarryIn0;
    logic        Last0;
    logic        Gnt0;
    logic        Req1;
    logic [63:0] X1;
    logic [63:0] Y1;
    logic        CarryIn1;
    logic        Last1;
    logic        Gnt1;
`ifdef ADDER64_ARB_SUB_EN
    logic        Sub0;
    logic        Sub1;
`endif
    logic        OutValid;
    logic        OutId;
    logic [63:0] Sum;
    logic        CarryOut;
    logic        OutLast;
    logic        OutOvf;
    logic        Busy;

    modport master (
`ifdef ADDER64_ARB_SUB_EN
        output Sub0, Sub1,
`endif
        output Req0, X0, Y0, CarryIn0, Last0,
        output Req1, X1, Y1, CarryIn1, Last1,
        input  Gnt0, Gnt1,
        input  OutValid, OutId, Sum, CarryOut, OutLast, OutOvf, Busy
    );

    modport slave (
`ifdef ADDER64_ARB_SUB_EN
        input  Sub0, Sub1,
`endif
        input  Req0, X0, Y0, CarryIn0, Last0,
        input  Req1, X1, Y1, CarryIn1, Last1,
        output Gnt0, Gnt1,
        output OutValid, OutId, Sum, CarryOut, OutLast, OutOvf, Busy
    );
endinterface

// File: rtl/adder64_arbiter.sv
// rtl/adder64_arbiter.sv - round-robin burst arbiter for one shared 64-bit adder with chained carry
// Defining ADDER64_ARB_SUB_EN adds per-burst subtract mode (Sub0/Sub1).
module adder64_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 3
) (
    input  logic               Clk,
    input  logic               Rst_n,
    adder64_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              ptr;
    logic              carry_q;
    logic [CNT_W-1:0]  cnt;

    logic              sel;
    logic              req_sel;
    logic              last_sel;
    logic              cin_sel;
    logic [63:0]       x_sel;
    logic [63:0]       y_sel;
    logic              xfer;
    logic              first;
    logic              forced;
    logic              end_burst;
    logic              sub_eff;
    logic [63:0]       op_y;
    logic              cin;
    logic [64:0]       add_res;

    logic              out_valid_q;
    logic              out_id_q;
    logic [63:0]       sum_q;
    logic              carry_out_q;
    logic              out_last_q;
    logic              out_ovf_q;

`ifdef ADDER64_ARB_SUB_EN
    logic              sub_q;
`endif

    always_comb begin
        sel      = (state == GRANT1);
        req_sel  = sel ? bus.Req1     : bus.Req0;
        last_sel = sel ? bus.Last1    : bus.Last0;
        cin_sel  = sel ? bus.CarryIn1 : bus.CarryIn0;
        x_sel    = sel ? bus.X1       : bus.X0;
        y_sel    = sel ? bus.Y1       : bus.Y0;
        xfer      = (state != IDLE) && req_sel;
        first     = (cnt == '0);
        forced    = (cnt == CNT_W'(MAX_BURST - 1));
        end_burst = xfer && (last_sel || forced);
`ifdef ADDER64_ARB_SUB_EN
        // Sub is taken live on the first word and from the latch afterwards.
        sub_eff = first ? (sel ? bus.Sub1 : bus.Sub0) : sub_q;
`else
        sub_eff = 1'b0;
`endif
        op_y    = sub_eff ? ~y_sel : y_sel;
        cin     = first ? (sub_eff | cin_sel) : carry_q;
        add_res = {1'b0, x_sel} + {1'b0, op_y} + {64'd0, cin};
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.Req0 && bus.Req1) begin
                    state_nxt = ptr ? GRANT1 : GRANT0;
                end else if (bus.Req0) begin
                    state_nxt = GRANT0;
                end else if (bus.Req1) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (end_burst) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            ptr         <= 1'b0;
            carry_q     <= 1'b0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= 1'b0;
            sum_q       <= 64'd0;
            carry_out_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
`ifdef ADDER64_ARB_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            out_valid_q <= xfer;
            out_last_q  <= end_burst;
            out_ovf_q   <= end_burst && !last_sel;
            if (xfer) begin
                out_id_q    <= sel;
                sum_q       <= add_res[63:0];
                carry_out_q <= add_res[64];
            end
            if (end_burst) begin
                ptr     <= ~sel;
                cnt     <= '0;
                carry_q <= 1'b0;
            end else if (xfer) begin
                cnt     <= cnt + CNT_W'(1);
                carry_q <= add_res[64];
`ifdef ADDER64_ARB_SUB_EN
                sub_q   <= sub_eff;
`endif
            end
        end
    end

    assign bus.Gnt0     = (state == GRANT0);
    assign bus.Gnt1     = (state == GRANT1);
    assign bus.Busy     = (state != IDLE);
    assign bus.OutValid = out_valid_q;
    assign bus.OutId    = out_id_q;
    assign bus.Sum      = sum_q;
    assign bus.CarryOut = carry_out_q;
    assign bus.OutLast  = out_last_q;
    assign bus.OutOvf   = out_ovf_q;
endmodule

// File: tb/tb_adder64_arbiter.sv
// tb/tb_adder64_arbiter.sv - directed scoreboard bench for adder64_arbiter
module tb_adder64_arbiter;
    localparam int MAXB = 8;

    typedef struct {
        logic        id;
        logic [63:0] sum;
        logic        co;
        logic        last;
        logic        ovf;
    } exp_t;

    logic        Clk;
    logic        Rst_n;
    logic [1:0]  sub_drv;
    exp_t        q[$];
    int          n_vec;
    int          n_err;
    int          m_k[2];
    logic        m_carry[2];
    logic        m_sub[2];

    adder64_arbiter_if bus ();

    adder64_arbiter #(.MAX_BURST(MAXB), .CNT_W(3)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

`ifdef ADDER64_ARB_SUB_EN
    assign bus.Sub0 = sub_drv[0];
    assign bus.Sub1 = sub_drv[1];
`endif

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic gnt(input int id);
        return (id == 0) ? bus.Gnt0 : bus.Gnt1;
    endfunction

    task automatic step();
        exp_t e;
        @(posedge Clk);
        #1;
        chk("out_valid", {63'd0, bus.OutValid}, {63'd0, q.size() != 0});
        if (bus.OutValid === 1'b1 && q.size() != 0) begin
            e = q.pop_front();
            chk("out_id",    {63'd0, bus.OutId},    {63'd0, e.id});
            chk("sum",       bus.Sum,               e.sum);
            chk("carry_out", {63'd0, bus.CarryOut}, {63'd0, e.co});
            chk("out_last",  {63'd0, bus.OutLast},  {63'd0, e.last});
            chk("out_ovf",   {63'd0, bus.OutOvf},   {63'd0, e.ovf});
        end
    endtask

    task automatic drive(input int id, input logic req, input logic [63:0] x, input logic [63:0] y,
                         input logic cin, input logic last);
        if (id == 0) begin
            bus.Req0 = req; bus.X0 = x; bus.Y0 = y; bus.CarryIn0 = cin; bus.Last0 = last;
        end else begin
            bus.Req1 = req; bus.X1 = x; bus.Y1 = y; bus.CarryIn1 = cin; bus.Last1 = last;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_k[i] = 0;
            m_carry[i] = 1'b0;
            m_sub[i] = 1'b0;
        end
        q.delete();
    endtask

    // Presents one word, waits (bounded) for the grant, predicts the result, then clocks it in.
    task automatic xfer(input int id, input logic [63:0] x, input logic [63:0] y,
                        input logic cin, input logic last);
        exp_t        e;
        logic [64:0] r;
        logic [63:0] yy;
        logic        c;
        logic        s;
        int          n;
        drive(id, 1'b1, x, y, cin, last);
        n = 0;
        while (gnt(id) !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        if (gnt(id) !== 1'b1) chk("gnt_wait", {63'd0, gnt(id)}, 64'd1);
        s  = (m_k[id] == 0) ? sub_drv[id] : m_sub[id];
        yy = s ? ~y : y;
        c  = (m_k[id] == 0) ? (s ? 1'b1 : cin) : m_carry[id];
        r  = {1'b0, x} + {1'b0, yy} + 65'(c);
        e.id   = id[0];
        e.sum  = r[63:0];
        e.co   = r[64];
        e.last = last || (m_k[id] == MAXB - 1);
        e.ovf  = !last && (m_k[id] == MAXB - 1);
        q.push_back(e);
        if (e.last) begin
            m_k[id] = 0;
            m_carry[id] = 1'b0;
        end else begin
            m_k[id]++;
            m_carry[id] = r[64];
            m_sub[id] = s;
        end
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        sub_drv = 2'b00;
        Rst_n = 1'b0;
        model_reset();
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        drive(1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_busy",   {63'd0, bus.Busy},     64'd0);
        chk("rst_gnt0",   {63'd0, bus.Gnt0},     64'd0);
        chk("rst_gnt1",   {63'd0, bus.Gnt1},     64'd0);
        chk("rst_sum",    bus.Sum,               64'd0);
        chk("rst_co",     {63'd0, bus.CarryOut}, 64'd0);
        chk("rst_id",     {63'd0, bus.OutId},    64'd0);
        chk("rst_last",   {63'd0, bus.OutLast},  64'd0);
        chk("rst_ovf",    {63'd0, bus.OutOvf},   64'd0);
        Rst_n = 1'b1;

        // Single word, one arbitration cycle before the grant.
        drive(0, 1'b1, 64'd1, 64'd1, 1'b0, 1'b1);
        step();
        chk("t1_gnt0_after_arb", {63'd0, bus.Gnt0}, 64'd1);
        xfer(0, 64'd1, 64'd1, 1'b0, 1'b1);
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        chk("t1_busy_idle", {63'd0, bus.Busy}, 64'd0);

        // Two-word carry chain on requester 1.
        xfer(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        xfer(1, 64'd200, 64'd400, 1'b0, 1'b1);
        drive(1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);

        // Contention from reset, then round-robin.
        Rst_n = 1'b0;
        step();
        Rst_n = 1'b1;
        model_reset();
        drive(1, 1'b1, 64'd10, 64'd20, 1'b1, 1'b1);
        drive(0, 1'b1, 64'd3, 64'd4, 1'b0, 1'b1);
        step();
        chk("cont_gnt0", {63'd0, bus.Gnt0}, 64'd1);
        chk("cont_gnt1", {63'd0, bus.Gnt1}, 64'd0);
        xfer(0, 64'd3, 64'd4, 1'b0, 1'b1);
        drive(0, 1'b1, 64'd50, 64'd60, 1'b1, 1'b1);
        chk("gap_busy", {63'd0, bus.Busy}, 64'd0);
        chk("gap_gnt1", {63'd0, bus.Gnt1}, 64'd0);
        step();
        chk("rr_gnt1", {63'd0, bus.Gnt1}, 64'd1);
        chk("rr_gnt0", {63'd0, bus.Gnt0}, 64'd0);
        xfer(1, 64'd10, 64'd20, 1'b1, 1'b1);
        drive(1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        xfer(0, 64'd50, 64'd60, 1'b1, 1'b1);
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);

        // Eight words without Last, two-cycle stall after a carry-producing word.
        for (int i = 0; i < MAXB; i++) begin
            if (i == 4) begin
                drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
                step();
                chk("stall_gnt0_a", {63'd0, bus.Gnt0}, 64'd1);
                step();
                chk("stall_gnt0_b", {63'd0, bus.Gnt0}, 64'd1);
            end
            if (i == 3) xfer(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
            else xfer(0, 64'(i * 1000 + 7), 64'hFFFF_FFFF_0000_0000 + 64'(i), 1'b1, 1'b0);
        end
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        chk("ovf_gnt_released", {63'd0, bus.Gnt0}, 64'd0);
        chk("ovf_busy",         {63'd0, bus.Busy}, 64'd0);

        // Reset arriving with the second word of a burst.
        xfer(0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 1'b0, 1'b0);
        drive(0, 1'b1, 64'd300, 64'd400, 1'b0, 1'b0);
        Rst_n = 1'b0;
        step();
        chk("mrst_busy", {63'd0, bus.Busy},     64'd0);
        chk("mrst_gnt0", {63'd0, bus.Gnt0},     64'd0);
        chk("mrst_sum",  bus.Sum,               64'd0);
        chk("mrst_co",   {63'd0, bus.CarryOut}, 64'd0);
        chk("mrst_last", {63'd0, bus.OutLast},  64'd0);
        model_reset();
        Rst_n = 1'b1;
        xfer(0, 64'd9999999, 64'd1, 1'b1, 1'b1);
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);

`ifdef ADDER64_ARB_SUB_EN
        sub_drv[0] = 1'b1;
        xfer(0, 64'd5, 64'd7, 1'b0, 1'b1);
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        sub_drv[1] = 1'b1;
        xfer(1, 64'd0, 64'd1, 1'b0, 1'b0);
        sub_drv[1] = 1'b0;
        xfer(1, 64'd1, 64'd0, 1'b0, 1'b1);
        drive(1, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        sub_drv = 2'b00;
`endif

        step();
        step();
        chk("sb_empty", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
